// File: rtl/ps2_tone_scheduler.sv
// PS/2 scan-code decoder for eight piano keys with a highest-pitch arbiter
// and a half-period divider that drives the square-wave tone output.
module ps2_tone_scheduler #(
    parameter int unsigned SIM_SHIFT = 0,
    parameter int unsigned DIV_W     = 17
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic [7:0] held,
    output logic       note_active,
    output logic [2:0] note_idx,
    output logic       tone
);

    localparam int unsigned HP_C4 = 95556;
    localparam int unsigned HP_D4 = 85132;
    localparam int unsigned HP_E4 = 75844;
    localparam int unsigned HP_F4 = 71586;
    localparam int unsigned HP_G4 = 63776;
    localparam int unsigned HP_A4 = 56818;
    localparam int unsigned HP_B4 = 50620;
    localparam int unsigned HP_C5 = 47778;

    localparam logic [7:0] CODE_BRK = 8'hF0;
    localparam logic [7:0] CODE_EXT = 8'hE0;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BRK     = 2'd1,
        S_EXT     = 2'd2,
        S_EXT_BRK = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             key_hit;
    logic [2:0]       key_idx;
    logic [7:0]       set_mask;
    logic [7:0]       clr_mask;
    logic             any_held;
    logic [2:0]       sel_idx;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] hp;

    function automatic logic [DIV_W-1:0] hp_of(input logic [2:0] idx);
        case (idx)
            3'd0:    return DIV_W'(HP_C4 >> SIM_SHIFT);
            3'd1:    return DIV_W'(HP_D4 >> SIM_SHIFT);
            3'd2:    return DIV_W'(HP_E4 >> SIM_SHIFT);
            3'd3:    return DIV_W'(HP_F4 >> SIM_SHIFT);
            3'd4:    return DIV_W'(HP_G4 >> SIM_SHIFT);
            3'd5:    return DIV_W'(HP_A4 >> SIM_SHIFT);
            3'd6:    return DIV_W'(HP_B4 >> SIM_SHIFT);
            default: return DIV_W'(HP_C5 >> SIM_SHIFT);
        endcase
    endfunction

    // Scan-code to piano key lookup
    always_comb begin
        key_hit = 1'b1;
        key_idx = 3'd0;
        case (byte_data)
            8'h1C:   key_idx = 3'd0;
            8'h1B:   key_idx = 3'd1;
            8'h23:   key_idx = 3'd2;
            8'h2B:   key_idx = 3'd3;
            8'h34:   key_idx = 3'd4;
            8'h33:   key_idx = 3'd5;
            8'h3B:   key_idx = 3'd6;
            8'h42:   key_idx = 3'd7;
            default: key_hit = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (byte_valid) begin
            case (state)
                S_IDLE: begin
                    if (byte_data == CODE_BRK)      state_nxt = S_BRK;
                    else if (byte_data == CODE_EXT) state_nxt = S_EXT;
                end
                S_BRK:     state_nxt = S_IDLE;
                S_EXT:     state_nxt = (byte_data == CODE_BRK) ? S_EXT_BRK : S_IDLE;
                default:   state_nxt = S_IDLE;
            endcase
        end
    end

    // Extended sequences fall through here with empty masks
    always_comb begin
        set_mask = 8'h00;
        clr_mask = 8'h00;
        if (byte_valid && key_hit) begin
            if (state == S_IDLE)     set_mask[key_idx] = 1'b1;
            else if (state == S_BRK) clr_mask[key_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) held <= 8'h00;
        else        held <= (held | set_mask) & ~clr_mask;
    end

    // Highest set index wins
    always_comb begin
        any_held = |held;
        sel_idx  = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (held[i]) sel_idx = 3'(i);
        end
    end

    assign hp = hp_of(note_idx);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            note_active <= 1'b0;
            note_idx    <= 3'd0;
            cnt         <= '0;
            tone        <= 1'b0;
        end else begin
            note_active <= any_held;
            note_idx    <= sel_idx;
            if (!any_held) begin
                cnt  <= '0;
                tone <= 1'b0;
            end else if (!note_active || (sel_idx != note_idx)) begin
                // Restart the period; level is kept across a note change
                cnt  <= '0;
                tone <= note_active ? tone : 1'b0;
            end else if (cnt == hp - DIV_W'(1)) begin
                cnt  <= '0;
                tone <= ~tone;
            end else begin
                cnt  <= cnt + DIV_W'(1);
            end
        end
    end

endmodule
